imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 10 +
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the upstream boot source into the loader.
// master = byte source, slave = loader.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory boot loader: takes a 16-bit big-endian word count
// followed by big-endian 32-bit words from a byte stream, writes them to
// consecutive instruction-memory addresses and holds the core in reset
// until the load finishes.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      in_if,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int unsigned DEPTH_U = DEPTH;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_q, word_d;
  logic [15:0]       words_loaded_q, words_loaded_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              ready;
  logic              accept;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_LEN_HI;
      count_q        <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      words_loaded_q <= '0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      words_loaded_q <= words_loaded_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
    end
  end

  // Next-state logic, byte acceptance and word assembly.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    words_loaded_d = words_loaded_q;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    imem_we        = 1'b0;

    ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
    accept = ready && in_if.in_valid;

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          count_d = {in_if.in_data, count_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          count_d = {count_q[15:8], in_if.in_data};
          if (count_d == '0) begin
            state_d = S_DONE;
          end else if ({16'd0, count_d} > DEPTH_U) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d     = {word_q[15:0], in_if.in_data};
          byte_idx_d = byte_idx_q + 2'd1;
          // Write address/data are captured on the fourth byte so they are
          // already stable during WRITE and simply hold afterwards.
          if (byte_idx_q == 2'd3) begin
            imem_addr_d  = words_loaded_q[ADDR_W-1:0];
            imem_wdata_d = {word_q, in_if.in_data};
            state_d      = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        imem_we        = 1'b1;
        words_loaded_d = words_loaded_q + 16'd1;
        state_d        = (words_loaded_d == count_q) ? S_DONE : S_DATA;
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d        = S_LEN_HI;
          words_loaded_d = '0;
          byte_idx_d     = '0;
          count_d        = '0;
        end
      end
      default: begin
        state_d = S_LEN_HI;
      end
    endcase
  end

  assign in_if.in_ready = ready;
  assign imem_addr      = imem_addr_q;
  assign imem_wdata     = imem_wdata_q;
  assign words_loaded   = words_loaded_q;
  assign cpu_reset      = (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of complete load streams plus
// hand-written sequences for stalls, restarts and mid-load reset. Expected
// memory writes are queued when a stream is driven and popped by a monitor
// whenever imem_we is seen.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  imem_loader_if bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (bus.slave),
    .start        (start),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int          n;      // bytes in stream
    logic [79:0] bytes;  // first byte in [79:72]
    logic        done;
    logic        err;
    logic [15:0] wl;
    int          nexp;   // expected writes
    logic [63:0] words;  // word 0 in [63:32]
    int          lat;    // cycles from last byte accept to done/error
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next queued write.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e.a));
        check("write_data", imem_wdata, e.d);
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle(1);
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: byte %h got in_ready 0 expected 1 within 20 cycles", b);
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic wait_end(output int lat);
    lat = 0;
    while (!(done || error) && lat < 40) begin
      cycle(1);
      lat++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"},        32'(imem_we), 32'd0);
    check({tag, "_addr"},      32'(imem_addr), 32'd0);
    check({tag, "_wdata"},     imem_wdata, 32'd0);
    check({tag, "_wl"},        32'(words_loaded), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_error"},     32'(error), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    vecs[0] = '{n: 10, bytes: 80'h0002_0022_0820_5042_0002, done: 1'b1, err: 1'b0,
                wl: 16'd2, nexp: 2, words: 64'h00220820_50420002, lat: 1};
    vecs[1] = '{n: 2, bytes: {16'h0000, 64'h0}, done: 1'b1, err: 1'b0,
                wl: 16'd0, nexp: 0, words: 64'h0, lat: 0};
    vecs[2] = '{n: 2, bytes: {16'h0401, 64'h0}, done: 1'b0, err: 1'b1,
                wl: 16'd0, nexp: 0, words: 64'h0, lat: 0};
    vecs[3] = '{n: 6, bytes: {48'h0001_DEAD_BEEF, 32'h0}, done: 1'b1, err: 1'b0,
                wl: 16'd1, nexp: 1, words: {32'hDEADBEEF, 32'h0}, lat: 1};

    // Table-driven complete loads.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      check_reset_state($sformatf("v%0d_reset", v));
      for (int k = 0; k < vecs[v].nexp; k++)
        push_wr(ADDR_W'(k), vecs[v].words[63 - 32*k -: 32]);
      for (int i = 0; i < vecs[v].n; i++)
        send_byte(vecs[v].bytes[79 - 8*i -: 8]);
      wait_end(lat);
      check($sformatf("v%0d_latency", v),   32'(lat), 32'(vecs[v].lat));
      check($sformatf("v%0d_done", v),      32'(done), 32'(vecs[v].done));
      check($sformatf("v%0d_error", v),     32'(error), 32'(vecs[v].err));
      check($sformatf("v%0d_wl", v),        32'(words_loaded), 32'(vecs[v].wl));
      check($sformatf("v%0d_cpu_reset", v), 32'(cpu_reset), 32'(!vecs[v].done));
      check($sformatf("v%0d_in_ready", v),  32'(bus.in_ready), 32'd0);
      check($sformatf("v%0d_pending", v),   32'(exp_q.size()), 32'd0);
      if (vecs[v].nexp > 0) begin
        check($sformatf("v%0d_hold_addr", v), 32'(imem_addr), 32'(vecs[v].nexp - 1));
        check($sformatf("v%0d_hold_data", v), imem_wdata,
              vecs[v].words[63 - 32*(vecs[v].nexp - 1) -: 32]);
      end
      if (vecs[v].err) begin
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        check($sformatf("v%0d_restart_error", v),    32'(error), 32'd0);
        check($sformatf("v%0d_restart_in_ready", v), 32'(bus.in_ready), 32'd1);
        check($sformatf("v%0d_restart_cpu_rst", v),  32'(cpu_reset), 32'd1);
      end
    end

    // Stall between bytes 2 and 3 of a word, with an ignored start pulse.
    do_reset();
    push_wr('0, 32'h6010005A);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h60);
    send_byte(8'h10);
    for (int g = 0; g < 3; g++) begin
      start = (g == 1);
      cycle(1);
      check("gap_in_ready", 32'(bus.in_ready), 32'd1);
      check("gap_done",     32'(done), 32'd0);
    end
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h5A);
    wait_end(lat);
    check("gap_latency", 32'(lat), 32'd1);
    check("gap_wl",      32'(words_loaded), 32'd1);
    check("gap_pending", 32'(exp_q.size()), 32'd0);

    // Bytes offered in DONE are not consumed; start then reloads.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    cycle(3);
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    check("done_stays",    32'(done), 32'd1);
    check("done_wl_hold",  32'(words_loaded), 32'd1);
    bus.in_valid = 1'b0;
    start = 1'b1;
    cycle(1);
    start = 1'b0;
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("restart_done",      32'(done), 32'd0);
    check("restart_wl",        32'(words_loaded), 32'd0);
    check("restart_in_ready",  32'(bus.in_ready), 32'd1);
    push_wr('0, 32'h11223344);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_end(lat);
    check("reload_done",      32'(done), 32'd1);
    check("reload_wl",        32'(words_loaded), 32'd1);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd0);

    // Reset during DATA after two bytes of the second word.
    do_reset();
    push_wr('0, 32'h01020304);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h55);
    send_byte(8'h66);
    do_reset();
    check_reset_state("midreset");
    push_wr('0, 32'hAABBCCDD);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    wait_end(lat);
    check("midreset_done",    32'(done), 32'd1);
    check("midreset_wl",      32'(words_loaded), 32'd1);
    check("midreset_pending", 32'(exp_q.size()), 32'd0);

    // Reset beats a valid byte and a start pulse in the same cycle.
    reset        = 1'b0;
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    cycle(1);
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    check("prio_in_ready", 32'(bus.in_ready), 32'd1);
    check("prio_done",     32'(done), 32'd0);
    send_byte(8'h00);
    check("prio_after_one_byte", 32'(done), 32'd0);
    send_byte(8'h00);
    check("prio_after_header", 32'(done), 32'd1);

    // Count exactly DEPTH is accepted.
    do_reset();
    send_byte(8'h04);
    send_byte(8'h00);
    check("depth_error",    32'(error), 32'd0);
    check("depth_in_ready", 32'(bus.in_ready), 32'd1);
    check("depth_done",     32'(done), 32'd0);
    do_reset();
    cycle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
